// File: rtl/core_pkg.sv
// Shared core types and constants for the fetch and decode stages.
package core_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fdb_storage.sv
// Entry storage for the fetch/decode buffer.
// One synchronous write port and one asynchronous read port; contents are never reset.
module fdb_storage #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // write port: capture the accepted entry at the write pointer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Elastic FIFO between instruction fetch and decode, with valid/ready on both sides
// and a synchronous flush that discards wrong-path entries.
module fetch_decode_buffer #(
  parameter int DEPTH = 2,
  parameter int XLEN  = core_pkg::XLEN,
  parameter int ILEN  = core_pkg::ILEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [ILEN-1:0]            in_instr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ILEN-1:0]            out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  import core_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PKT_W = XLEN + ILEN;

  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             empty_r, full_r;
  logic             push_s, pop_s;
  logic [PKT_W-1:0] rd_data_s;

  assign push_s = in_valid && !full_r && !flush;
  assign pop_s  = !empty_r && out_ready && !flush;

  fdb_storage #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W),
    .AW    (PTR_W)
  ) u_storage (
    .clk     (clk),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_r),
    .wr_data ({in_pc, in_instr}),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  // next pointer/occupancy; flush overrides any same-cycle push or pop
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (flush) begin
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      count_nxt_s  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_W'(1);
        2'b01:   count_nxt_s = count_r - CNT_W'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // state registers; status flags are registered alongside the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      empty_r  <= (count_nxt_s == {CNT_W{1'b0}});
      full_r   <= (count_nxt_s == CNT_W'(DEPTH));
    end
  end

  assign in_ready  = !full_r;
  assign out_valid = !empty_r;
  assign count     = count_r;
  assign empty     = empty_r;
  assign full      = full_r;

  // stale storage is masked so decode sees a harmless NOP when nothing is buffered
  assign out_pc    = empty_r ? {XLEN{1'b0}} : rd_data_s[PKT_W-1:ILEN];
  assign out_instr = empty_r ? ILEN'(NOP_INSTR) : rd_data_s[ILEN-1:0];

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed vector table, async-reset
// sequence, and randomized traffic against a queue-based reference model.
module tb_fetch_decode_buffer;
  import core_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk;
  logic             reset;
  logic             in_valid, in_ready;
  logic [63:0]      in_pc;
  logic [31:0]      in_instr;
  logic             flush;
  logic             out_valid, out_ready;
  logic [63:0]      out_pc;
  logic [31:0]      out_instr;
  logic [CNT_W-1:0] count;
  logic             empty, full;

  fetch_decode_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pkt_t model_q[$];
  logic       last_push;

  typedef struct {
    logic        iv;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        ordy;
    logic        fl;
    int          e_count;
    logic        e_ov;
    logic        e_ir;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare every DUT output against the reference queue
  task automatic check_model(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".count"},     64'(count),     64'(n));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(n > 0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(n < DEPTH));
    chk({tag, ".empty"},     64'(empty),     64'(n == 0));
    chk({tag, ".full"},      64'(full),      64'(n == DEPTH));
    chk({tag, ".out_pc"},    out_pc,         (n > 0) ? model_q[0].pc : 64'h0);
    chk({tag, ".out_instr"}, 64'(out_instr), 64'((n > 0) ? model_q[0].instr : NOP_INSTR));
  endtask

  // drive one cycle of inputs, check current outputs, advance model and clock
  task automatic step(input logic iv, input logic [63:0] pc, input logic [31:0] instr,
                      input logic ordy, input logic fl, input string tag);
    logic do_push, do_pop;
    fetch_pkt_t p;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = ordy;
    flush     = fl;
    check_model(tag);
    do_push = iv && (model_q.size() < DEPTH) && !fl;
    do_pop  = (model_q.size() > 0) && ordy && !fl;
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        p.pc = pc;
        p.instr = instr;
        model_q.push_back(p);
      end
    end
    last_push = do_push;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        h_iv;
    logic [63:0] h_pc;
    logic [31:0] h_instr;

    vecs[0]  = '{1'b1, 64'h00, 32'h00500093, 1'b1, 1'b0, 1, 1'b1, 1'b1, 64'h00, 32'h00500093};
    vecs[1]  = '{1'b0, 64'h00, 32'h00000000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 64'h00, 32'h00000013};
    vecs[2]  = '{1'b1, 64'h00, 32'h00000093, 1'b0, 1'b0, 1, 1'b1, 1'b1, 64'h00, 32'h00000093};
    vecs[3]  = '{1'b1, 64'h04, 32'h00400093, 1'b0, 1'b0, 2, 1'b1, 1'b0, 64'h00, 32'h00000093};
    vecs[4]  = '{1'b1, 64'h08, 32'h00800093, 1'b0, 1'b0, 2, 1'b1, 1'b0, 64'h00, 32'h00000093};
    vecs[5]  = '{1'b1, 64'h08, 32'h00800093, 1'b1, 1'b0, 1, 1'b1, 1'b1, 64'h04, 32'h00400093};
    vecs[6]  = '{1'b1, 64'h08, 32'h00800093, 1'b1, 1'b0, 1, 1'b1, 1'b1, 64'h08, 32'h00800093};
    vecs[7]  = '{1'b0, 64'h00, 32'h00000000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 64'h00, 32'h00000013};
    vecs[8]  = '{1'b1, 64'h10, 32'h01000093, 1'b0, 1'b0, 1, 1'b1, 1'b1, 64'h10, 32'h01000093};
    vecs[9]  = '{1'b1, 64'h14, 32'h01400093, 1'b0, 1'b0, 2, 1'b1, 1'b0, 64'h10, 32'h01000093};
    vecs[10] = '{1'b1, 64'h18, 32'h01800093, 1'b1, 1'b1, 0, 1'b0, 1'b1, 64'h00, 32'h00000013};
    vecs[11] = '{1'b1, 64'h40, 32'h04000093, 1'b0, 1'b0, 1, 1'b1, 1'b1, 64'h40, 32'h04000093};
    vecs[12] = '{1'b0, 64'h00, 32'h00000000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 64'h00, 32'h00000013};
    vecs[13] = '{1'b0, 64'h00, 32'h00000000, 1'b1, 1'b1, 0, 1'b0, 1'b1, 64'h00, 32'h00000013};
    vecs[14] = '{1'b1, 64'h44, 32'h04400093, 1'b0, 1'b0, 1, 1'b1, 1'b1, 64'h44, 32'h04400093};
    vecs[15] = '{1'b1, 64'h48, 32'h04800093, 1'b1, 1'b0, 1, 1'b1, 1'b1, 64'h48, 32'h04800093};
    vecs[16] = '{1'b0, 64'h00, 32'h00000000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 64'h00, 32'h00000013};

    reset = 1'b1;
    in_valid = 1'b0; in_pc = 64'h0; in_instr = 32'h0;
    out_ready = 1'b0; flush = 1'b0;
    last_push = 1'b0;

    // reset held for two cycles, then released
    repeat (2) @(posedge clk);
    #1;
    check_model("reset_hold");
    reset = 1'b0;
    #1;
    check_model("reset_rel");
    @(posedge clk);
    #1;

    // directed vector table
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].ordy, vecs[i].fl, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.count", i),     64'(count),     64'(vecs[i].e_count));
      chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("vec%0d.in_ready", i),  64'(in_ready),  64'(vecs[i].e_ir));
      chk($sformatf("vec%0d.out_pc", i),    out_pc,         vecs[i].e_pc);
      chk($sformatf("vec%0d.out_instr", i), 64'(out_instr), 64'(vecs[i].e_instr));
    end

    // streaming at count=1 across pointer wrap
    step(1'b1, 64'h100, 32'h10000093, 1'b0, 1'b0, "stream_fill");
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 64'h100 + 64'(4*i), 32'h10000093 + 32'(i), 1'b1, 1'b0, $sformatf("stream%0d", i));
      chk($sformatf("stream%0d.count", i), 64'(count), 64'h1);
      chk($sformatf("stream%0d.pc", i), out_pc, 64'h100 + 64'(4*i));
    end
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, "stream_drain");

    // asynchronous reset between edges with two entries buffered
    step(1'b1, 64'h200, 32'h20000093, 1'b0, 1'b0, "ar_a");
    step(1'b1, 64'h204, 32'h20400093, 1'b0, 1'b0, "ar_b");
    in_valid = 1'b0;
    chk("ar_pre.count", 64'(count), 64'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar.count",     64'(count),     64'h0);
    chk("ar.out_valid", 64'(out_valid), 64'h0);
    chk("ar.in_ready",  64'(in_ready),  64'h1);
    chk("ar.out_pc",    out_pc,         64'h0);
    chk("ar.out_instr", 64'(out_instr), 64'h13);
    model_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 64'h300, 32'h30000093, 1'b0, 1'b0, "ar_push");
    chk("ar_push.out_pc", out_pc, 64'h300);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, "ar_pop");

    // randomized traffic; source holds its entry while it is not accepted
    h_iv = 1'b0; h_pc = 64'h0; h_instr = 32'h0;
    for (int i = 0; i < 500; i++) begin
      logic fl;
      if (!(h_iv && !last_push)) begin
        h_iv    = ($urandom_range(0, 9) < 7);
        h_pc    = {32'h0, $urandom} & 64'hFFFF_FFFC;
        h_instr = $urandom;
      end
      fl = ($urandom_range(0, 19) == 0);
      step(h_iv, h_pc, h_instr, ($urandom_range(0, 9) < 6), fl, $sformatf("rnd%0d", i));
      if (fl) h_iv = 1'b0;
    end
    check_model("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
